// File: rtl/btn_pkg.sv
// btn_pkg
//   Shared definitions for button event handling. The same package is used
//   by the clock and alarm setting logic.
//   - btn_state_t : FSM state encoding
//   - BTN_HOLD_CYC_DFLT / BTN_REPEAT_CYC_DFLT : default timing at 100 MHz
//   - btn_cnt_width() : counter width for a given pair of terminal counts
package btn_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_HOLD = 2'd1,
      REPEAT    = 2'd2,
      LATCHED   = 2'd3
   } btn_state_t;

   // 0.5 s long-press and 0.1 s auto-repeat at 100 MHz
   localparam int unsigned BTN_HOLD_CYC_DFLT   = 50000000;
   localparam int unsigned BTN_REPEAT_CYC_DFLT = 10000000;

   // Width needed to count 0 .. max(a,b)-1
   function automatic int unsigned btn_cnt_width(input int unsigned a,
                                                 input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/terminal_counter.sv
// terminal_counter
//   Up-counter with synchronous clear, count enable and a terminal-count
//   flag. When enabled at the terminal value it wraps to 0, so the count
//   never exceeds i_term.
//   Ports:
//     clk     : clock
//     rst     : asynchronous active-high reset
//     i_clr   : synchronous clear (wins over i_en)
//     i_en    : count enable
//     i_term  : terminal value
//     o_tc    : high while the count equals i_term
module terminal_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_term,
   output logic             o_tc
);

   logic [WIDTH-1:0] r_count;
   logic             w_at_term;

   assign w_at_term = (r_count == i_term);
   assign o_tc      = w_at_term;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en) begin
         if (w_at_term) begin
            r_count <= '0;
         end else begin
            r_count <= r_count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/button_event_gen.sv
// button_event_gen
//   Turns a debounced button level into press / long-press / auto-repeat
//   strobes. All outputs are registered.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | button released, waiting for a new press
//   WAIT_HOLD | pressed, counting towards the long-press threshold
//   REPEAT    | long press reached, emitting repeat_pulse every REPEAT_CYC
//   LATCHED   | long press reached, no auto-repeat, waiting for release
//
//   Build option: define BTN_AUTOREPEAT_EN to include the REPEAT state and
//   repeat_pulse generation. Without it, long presses go to LATCHED and
//   repeat_pulse is tied low.
//
//   Parameters:
//     HOLD_CYC   : held cycles before long_pulse (>= 2)
//     REPEAT_CYC : cycles between repeat_pulse strobes (>= 2)
//   Ports:
//     clk          : clock
//     rst          : asynchronous active-high reset
//     btn_db       : debounced, clk-synchronous button level (1 = pressed)
//     press_pulse  : one-cycle strobe on each new press
//     long_pulse   : one-cycle strobe when the press reaches HOLD_CYC cycles
//     repeat_pulse : one-cycle strobe every REPEAT_CYC cycles after a long press
//     held         : high while the press is being tracked
module button_event_gen
   import btn_pkg::*;
#(
   parameter int unsigned HOLD_CYC   = BTN_HOLD_CYC_DFLT,
   parameter int unsigned REPEAT_CYC = BTN_REPEAT_CYC_DFLT
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_db,
   output logic press_pulse,
   output logic long_pulse,
   output logic repeat_pulse,
   output logic held
);

   localparam int unsigned CNT_W = btn_cnt_width(HOLD_CYC, REPEAT_CYC);
   localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(HOLD_CYC - 1);
`ifdef BTN_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_CYC - 1);
`endif

   btn_state_t       r_state;
   logic             r_press;
   logic             r_long;
   logic             r_held;
`ifdef BTN_AUTOREPEAT_EN
   logic             r_repeat;
`endif

   logic             w_cnt_clr;
   logic             w_cnt_en;
   logic             w_cnt_tc;
   logic [CNT_W-1:0] w_cnt_term;

`ifdef BTN_AUTOREPEAT_EN
   assign w_cnt_term = (r_state == REPEAT) ? REPEAT_TERM : HOLD_TERM;
`else
   assign w_cnt_term = HOLD_TERM;
`endif

   // The counter only runs while the button stays down in a counting
   // state. Leaving WAIT_HOLD on terminal count clears it so REPEAT starts
   // from 0; in REPEAT the counter wraps by itself at its terminal value.
   always_comb begin
      w_cnt_clr = 1'b1;
      w_cnt_en  = 1'b0;
      case (r_state)
         WAIT_HOLD: begin
            if (btn_db && !w_cnt_tc) begin
               w_cnt_clr = 1'b0;
               w_cnt_en  = 1'b1;
            end
         end
`ifdef BTN_AUTOREPEAT_EN
         REPEAT: begin
            if (btn_db) begin
               w_cnt_clr = 1'b0;
               w_cnt_en  = 1'b1;
            end
         end
`endif
         default: begin
            w_cnt_clr = 1'b1;
            w_cnt_en  = 1'b0;
         end
      endcase
   end

   terminal_counter #(
      .WIDTH (CNT_W)
   ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_cnt_clr),
      .i_en   (w_cnt_en),
      .i_term (w_cnt_term),
      .o_tc   (w_cnt_tc)
   );

   // Release is checked before any terminal count, so a release sampled on
   // the same edge as a terminal count suppresses the pulse. IDLE is only
   // re-entered after a sampled release, which makes press_pulse
   // edge-triggered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_press  <= 1'b0;
         r_long   <= 1'b0;
         r_held   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
         r_repeat <= 1'b0;
`endif
      end else begin
         r_press  <= 1'b0;
         r_long   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
         r_repeat <= 1'b0;
`endif
         case (r_state)
            IDLE: begin
               if (btn_db) begin
                  r_press <= 1'b1;
                  r_held  <= 1'b1;
                  r_state <= WAIT_HOLD;
               end else begin
                  r_held  <= 1'b0;
               end
            end
            WAIT_HOLD: begin
               if (!btn_db) begin
                  r_held  <= 1'b0;
                  r_state <= IDLE;
               end else if (w_cnt_tc) begin
                  r_long  <= 1'b1;
                  r_held  <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                  r_state <= REPEAT;
`else
                  r_state <= LATCHED;
`endif
               end else begin
                  r_held  <= 1'b1;
               end
            end
`ifdef BTN_AUTOREPEAT_EN
            REPEAT: begin
               if (!btn_db) begin
                  r_held   <= 1'b0;
                  r_state  <= IDLE;
               end else begin
                  r_held   <= 1'b1;
                  r_repeat <= w_cnt_tc;
               end
            end
`endif
            LATCHED: begin
               if (!btn_db) begin
                  r_held  <= 1'b0;
                  r_state <= IDLE;
               end else begin
                  r_held  <= 1'b1;
               end
            end
            default: begin
               r_held  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign press_pulse  = r_press;
   assign long_pulse   = r_long;
   assign held         = r_held;
`ifdef BTN_AUTOREPEAT_EN
   assign repeat_pulse = r_repeat;
`else
   assign repeat_pulse = 1'b0;
`endif

endmodule

// File: doc/button_event_gen.md
BUTTON_EVENT_GEN -- requirements
Module: button_event_gen

Interface
REQ-001 Parameter HOLD_CYC, default 50000000, is the number of held cycles before a long-press event (0.5 s at 100 MHz).
REQ-002 Parameter REPEAT_CYC, default 10000000, is the number of cycles between auto-repeat events (0.1 s at 100 MHz).
REQ-003 Port clk, input, 1, is the system clock.
REQ-004 Port rst, input, 1, is the asynchronous, active-high reset.
REQ-005 Port btn_db, input, 1, is the debounced, clk-synchronous button level; 1 means pressed.
REQ-006 Port press_pulse, output, 1, is a one-cycle strobe on each new press.
REQ-007 Port long_pulse, output, 1, is a one-cycle strobe when a press reaches HOLD_CYC cycles.
REQ-008 Port repeat_pulse, output, 1, is a one-cycle strobe every REPEAT_CYC cycles after a long press.
REQ-009 Port held, output, 1, is a level that is high while the press is being tracked.

Function
REQ-010 The FSM SHALL have four states: IDLE, WAIT_HOLD, REPEAT and LATCHED; all outputs SHALL be registered.
REQ-011 In IDLE with btn_db=1 sampled at edge k, the block SHALL assert press_pulse for exactly the cycle after edge k, clear the counter and enter WAIT_HOLD.
REQ-012 In WAIT_HOLD the counter SHALL increment once per cycle; with btn_db=0 sampled, the FSM SHALL return to IDLE with no pulse and clear the counter.
REQ-013 In WAIT_HOLD, when the counter equals HOLD_CYC-1 and btn_db=1, the block SHALL assert long_pulse for one cycle, clear the counter and enter REPEAT (REQ-021) or LATCHED (REQ-022).
REQ-014 If release and terminal count occur in the same cycle, release SHALL win: no long_pulse, and the next state is IDLE.
REQ-015 In REPEAT, each time the counter reaches REPEAT_CYC-1 with btn_db=1, the block SHALL assert repeat_pulse for one cycle and the counter SHALL wrap to 0.
REQ-016 In REPEAT or LATCHED, btn_db=0 SHALL return the FSM to IDLE next cycle; release beats a simultaneous repeat terminal count.
REQ-017 held SHALL be 1 in WAIT_HOLD, REPEAT and LATCHED, and 0 in IDLE.
REQ-018 A new press_pulse SHALL require at least one sampled btn_db=0 cycle in between (edge-triggered, never level-triggered).
REQ-019 The counter width SHALL be $clog2 of the larger of HOLD_CYC and REPEAT_CYC; the counter SHALL never exceed its terminal value, and HOLD_CYC and REPEAT_CYC SHALL each be at least 2.

Reset
REQ-020 While rst=1, the state SHALL be IDLE, the counter 0, and press_pulse, long_pulse, repeat_pulse and held 0, asynchronously; after release, a btn_db already at 1 SHALL produce press_pulse per REQ-011.

Configuration
REQ-021 With macro BTN_AUTOREPEAT_EN defined, the FSM SHALL enter REPEAT after long_pulse and generate repeat_pulse per REQ-015.
REQ-022 Without BTN_AUTOREPEAT_EN, the REPEAT state and the repeat logic SHALL be absent, the FSM SHALL enter LATCHED after long_pulse, and repeat_pulse SHALL be tied to 0.

Structure
REQ-023 State encodings (IDLE=2'd0, WAIT_HOLD=2'd1, REPEAT=2'd2, LATCHED=2'd3) and the default timing constants SHALL live in shared package btn_pkg, reused by the clock and alarm setting logic.
REQ-024 A single sub-module, terminal_counter (parameterised width, synchronous clear, enable, terminal-count output), SHALL implement the hold and repeat counting.

Verification (HOLD_CYC=8, REPEAT_CYC=4)
REQ-025 Reset held with btn_db=1, then released -> all outputs 0 during reset; press_pulse in the 2nd cycle after rst falls.
REQ-026 btn_db high for 3 cycles, then low -> exactly one press_pulse, no long_pulse, held high for 3 cycles.
REQ-027 btn_db high for 20 cycles, macro defined -> press_pulse at cycle 1, long_pulse at cycle 9, repeat_pulse at cycles 13 and 17, held drops 1 cycle after release.
REQ-028 Same stimulus, macro undefined -> press_pulse and long_pulse only; repeat_pulse stays 0 throughout.
REQ-029 Release timed to land exactly on the hold terminal count -> no long_pulse, FSM in IDLE next cycle.
REQ-030 btn_db pattern 1,0,1 on consecutive cycles -> two press_pulses, each lasting one cycle.
